// File: rtl/serial_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_sequencer
//  Description : Bit-serial add/subtract sequencer. Streams a WIDTH-bit
//                operation through one external combinational full-adder
//                cell, LSB first, one bit per clock, and produces the result
//                together with ARM-style NZCV flags.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          : clock, all state updates on the rising edge
//    reset        : synchronous active-low reset
//    start_valid  : request present
//    start_ready  : sequencer can accept a request (IDLE only)
//    a, b, sub    : operands and operation select (1 = a-b), sampled on
//                   the start handshake
//    fa_a, fa_b   : operand bits to the full-adder cell (fa_b pre-inverted
//                   for subtract); forced to 0 outside RUN
//    fa_cin       : carry-in to the full-adder cell; 0 outside RUN
//    fa_sum       : sum bit from the full-adder cell
//    fa_cout      : carry-out from the full-adder cell
//    done_valid   : result and flags valid (DONE only)
//    done_ready   : consumer accepts the result
//    result       : a+b or a-b modulo 2^WIDTH
//    flag_n/z/c/v : negative, zero, carry (no-borrow on sub), overflow
// ============================================================================
module serial_add_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic              r_carry;
    logic [CW-1:0]     r_count;
    logic              r_zero_acc;
    logic              w_run;

    // The cell inputs are pure gating of registered state; the cell itself
    // sits between these outputs and the fa_sum/fa_cout inputs.
    assign w_run  = (r_state == S_RUN);
    assign fa_a   = w_run & r_a_sh[0];
    assign fa_b   = w_run & r_b_sh[0];
    assign fa_cin = w_run & r_carry;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_carry     <= 1'b0;
            r_count     <= '0;
            r_zero_acc  <= 1'b0;
            result      <= '0;
            flag_n      <= 1'b0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
            flag_v      <= 1'b0;
            start_ready <= 1'b1;
            done_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        // Subtract as a + ~b + 1: invert b once here and
                        // seed the carry with the +1.
                        r_a_sh      <= a;
                        r_b_sh      <= b ^ {WIDTH{sub}};
                        r_carry     <= sub;
                        r_count     <= '0;
                        r_zero_acc  <= 1'b0;
                        start_ready <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_a_sh     <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh     <= {1'b0, r_b_sh[WIDTH-1:1]};
                    result     <= {fa_sum, result[WIDTH-1:1]};
                    r_carry    <= fa_cout;
                    r_zero_acc <= r_zero_acc | fa_sum;
                    if (r_count == C_LAST) begin
                        // MSB cycle: carry into the MSB is fa_cin, so
                        // overflow is cin xor cout of this bit.
                        flag_c     <= fa_cout;
                        flag_v     <= fa_cin ^ fa_cout;
                        flag_n     <= fa_sum;
                        flag_z     <= ~(r_zero_acc | fa_sum);
                        done_valid <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end

                S_DONE: begin
                    if (done_ready) begin
                        done_valid  <= 1'b0;
                        start_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    done_valid  <= 1'b0;
                    start_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
